// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage controller sitting behind the EXE/MEM pipeline register.
// A load or store request becomes a req/ack handshake on the data-memory
// port; the upstream pipeline is stalled until the handshake completes, and
// the MEM/WB fields are registered for the writeback stage.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   aluout_in, rdata2_in      ALU result / address and store data
//   waddr_in, write_en_in     writeback register address and enable
//   mem_write_in, mem_read_in store / load request
//   mem_to_reg_in             WB mux select (1 = load data)
//   stall                     combinational hold request to upstream stages
//   dmem_req/we/addr/wdata    registered data-memory request, stable while req=1
//   dmem_ack, dmem_rdata      memory completion and read data
//   wb_*                      MEM/WB pipeline register outputs
//   stall_cycles              saturating count of stalled cycles
module mem_stage_ctrl #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int MAW   = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] aluout_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             write_en_in,
  input  logic             mem_write_in,
  input  logic             mem_read_in,
  input  logic             mem_to_reg_in,
  output logic             stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [MAW-1:0]   dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DSIZE-1:0] dmem_rdata,
  output logic [DSIZE-1:0] wb_aluout,
  output logic [DSIZE-1:0] wb_memdata,
  output logic [ASIZE-1:0] wb_waddr,
  output logic             wb_write_en,
  output logic             wb_mem_to_reg,
  output logic [CNTW-1:0]  stall_cycles
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state_q, state_d;
  logic             dmem_req_q, dmem_req_d;
  logic             dmem_we_q, dmem_we_d;
  logic [MAW-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DSIZE-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [DSIZE-1:0] rdata_hold_q, rdata_hold_d;
  logic [DSIZE-1:0] wb_aluout_q, wb_aluout_d;
  logic [DSIZE-1:0] wb_memdata_q, wb_memdata_d;
  logic [ASIZE-1:0] wb_waddr_q, wb_waddr_d;
  logic             wb_write_en_q, wb_write_en_d;
  logic             wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [CNTW-1:0]  stall_cycles_q, stall_cycles_d;
  logic             stall_c;
  logic             mem_op;

  assign mem_op = mem_read_in | mem_write_in;

  always_comb begin
    state_d         = state_q;
    dmem_req_d      = dmem_req_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_wdata_d    = dmem_wdata_q;
    rdata_hold_d    = rdata_hold_q;
    wb_aluout_d     = wb_aluout_q;
    wb_memdata_d    = wb_memdata_q;
    wb_waddr_d      = wb_waddr_q;
    wb_write_en_d   = wb_write_en_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    stall_cycles_d  = stall_cycles_q;
    stall_c         = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall_c      = 1'b1;
          state_d      = ACCESS;
          dmem_req_d   = 1'b1;
          // A simultaneous read+write resolves to a write.
          dmem_we_d    = mem_write_in;
          dmem_addr_d  = aluout_in[MAW-1:0];
          dmem_wdata_d = rdata2_in;
        end else begin
          wb_aluout_d     = aluout_in;
          wb_memdata_d    = '0;
          wb_waddr_d      = waddr_in;
          wb_write_en_d   = write_en_in;
          wb_mem_to_reg_d = mem_to_reg_in;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        if (dmem_ack) begin
          rdata_hold_d = dmem_we_q ? '0 : dmem_rdata;
          dmem_req_d   = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        // EXE/MEM still holds the op that was stalled, so it retires now.
        wb_aluout_d     = aluout_in;
        wb_memdata_d    = rdata_hold_q;
        wb_waddr_d      = waddr_in;
        wb_write_en_d   = write_en_in;
        wb_mem_to_reg_d = mem_to_reg_in;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Stalled cycles push a bubble into WB; data fields keep their values.
    if (stall_c) begin
      wb_write_en_d   = 1'b0;
      wb_mem_to_reg_d = 1'b0;
      if (stall_cycles_q != {CNTW{1'b1}}) begin
        stall_cycles_d = stall_cycles_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= '0;
      dmem_wdata_q    <= '0;
      rdata_hold_q    <= '0;
      wb_aluout_q     <= '0;
      wb_memdata_q    <= '0;
      wb_waddr_q      <= '0;
      wb_write_en_q   <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      stall_cycles_q  <= '0;
    end else begin
      state_q         <= state_d;
      dmem_req_q      <= dmem_req_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_wdata_q    <= dmem_wdata_d;
      rdata_hold_q    <= rdata_hold_d;
      wb_aluout_q     <= wb_aluout_d;
      wb_memdata_q    <= wb_memdata_d;
      wb_waddr_q      <= wb_waddr_d;
      wb_write_en_q   <= wb_write_en_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  // Gated by reset so stall drops immediately while reset is asserted,
  // even if a memory op is still presented on the inputs.
  assign stall         = stall_c & rst;
  assign dmem_req      = dmem_req_q;
  assign dmem_we       = dmem_we_q;
  assign dmem_addr     = dmem_addr_q;
  assign dmem_wdata    = dmem_wdata_q;
  assign wb_aluout     = wb_aluout_q;
  assign wb_memdata    = wb_memdata_q;
  assign wb_waddr      = wb_waddr_q;
  assign wb_write_en   = wb_write_en_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: directed instructions, a WB scoreboard
// monitor and a memory responder that checks requests and drives acks.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] aluout_in = '0, rdata2_in = '0;
  logic [3:0]  waddr_in = '0;
  logic        write_en_in = 1'b0, mem_write_in = 1'b0, mem_read_in = 1'b0, mem_to_reg_in = 1'b0;
  logic        stall, dmem_req, dmem_we;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = 16'hDEAD;
  logic [15:0] wb_aluout, wb_memdata;
  logic [3:0]  wb_waddr;
  logic        wb_write_en, wb_mem_to_reg;
  logic [15:0] stall_cycles;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst),
    .aluout_in(aluout_in), .rdata2_in(rdata2_in), .waddr_in(waddr_in),
    .write_en_in(write_en_in), .mem_write_in(mem_write_in),
    .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_aluout(wb_aluout), .wb_memdata(wb_memdata), .wb_waddr(wb_waddr),
    .wb_write_en(wb_write_en), .wb_mem_to_reg(wb_mem_to_reg),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] alu;
    logic [15:0] mem;
    logic [3:0]  waddr;
    logic        we;
    logic        m2r;
  } wb_t;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          dly;
    logic [15:0] rdata;
  } mem_t;

  wb_t  exp_wb_q[$];
  mem_t exp_mem_q[$];

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_total = 0;
  logic spur = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // WB monitor: a cycle with stall=0 retires one instruction, visible on
  // wb_* at the following sample point. Stalled cycles must show a bubble.
  logic pending = 1'b0;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst && pending) begin
      if (exp_wb_q.size() == 0) begin
        chk("wb_unexpected", 32'(1), 32'(0));
      end else begin
        wb_t e;
        e = exp_wb_q.pop_front();
        chk("wb_aluout", 32'(wb_aluout), 32'(e.alu));
        chk("wb_memdata", 32'(wb_memdata), 32'(e.mem));
        chk("wb_waddr", 32'(wb_waddr), 32'(e.waddr));
        chk("wb_write_en", 32'(wb_write_en), 32'(e.we));
        chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(e.m2r));
      end
    end else if (rst && prev_stall) begin
      chk("wb_bubble", 32'({wb_write_en, wb_mem_to_reg}), 32'(0));
    end
    pending    = rst && !stall;
    prev_stall = rst && stall;
  end

  // Memory responder: checks each new request, checks it stays stable,
  // and raises ack in ACCESS cycle 'dly' (ACCESS cycle 1 = first req cycle).
  mem_t cur;
  int   k = 0;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      k = 0; prev_req = 1'b0; dmem_ack = 1'b0;
    end else begin
      if (dmem_req) begin
        if (!prev_req) begin
          if (exp_mem_q.size() == 0) begin
            chk("mem_unexpected_req", 32'(1), 32'(0));
            cur = '{1'b0, 8'h0, 16'h0, 1, 16'h0};
          end else begin
            cur = exp_mem_q.pop_front();
            chk("dmem_we", 32'(dmem_we), 32'(cur.we));
            chk("dmem_addr", 32'(dmem_addr), 32'(cur.addr));
            chk("dmem_wdata", 32'(dmem_wdata), 32'(cur.wdata));
          end
          k = 1;
        end else begin
          k++;
          chk("dmem_hold", 32'({dmem_we, dmem_addr, dmem_wdata}),
              32'({cur.we, cur.addr, cur.wdata}));
        end
        if (k == cur.dly) begin
          dmem_ack = 1'b1; dmem_rdata = cur.rdata;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = 16'hDEAD;
        end
      end else begin
        k = 0;
        dmem_ack = spur;
        dmem_rdata = 16'hDEAD;
      end
      prev_req = dmem_req;
    end
  end

  task automatic issue(input string name, input logic [15:0] alu, input logic [15:0] rd2,
                       input logic [3:0] wa, input logic we, input logic mw, input logic mr,
                       input logic m2r, input int dly, input logic [15:0] rd);
    wb_t  w;
    mem_t m;
    int   n, exp_st;
    w.alu = alu; w.waddr = wa; w.we = we; w.m2r = m2r;
    w.mem = (mr && !mw) ? rd : 16'h0;
    exp_wb_q.push_back(w);
    exp_st = (mw || mr) ? dly + 1 : 0;
    if (mw || mr) begin
      m.we = mw; m.addr = alu[7:0]; m.wdata = rd2; m.dly = dly; m.rdata = rd;
      exp_mem_q.push_back(m);
    end
    aluout_in = alu; rdata2_in = rd2; waddr_in = wa; write_en_in = we;
    mem_write_in = mw; mem_read_in = mr; mem_to_reg_in = m2r;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 60) begin
        chk("stall_timeout", 32'(n), 32'(exp_st));
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    exp_total += exp_st;
    chk("stall_len", 32'(n), 32'(exp_st));
    chk("stall_cycles", 32'(stall_cycles), 32'(exp_total));
    $display("txn %s: alu=%h rd2=%h mw=%0d mr=%0d stall_len=%0d stall_cycles=%0d",
             name, alu, rd2, mw, mr, n, stall_cycles);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 32'(dmem_req), 32'(0));
    chk({tag, "_stall"}, 32'(stall), 32'(0));
    chk({tag, "_mem_if"}, 32'({dmem_we, dmem_addr, dmem_wdata}), 32'(0));
    chk({tag, "_wb_data"}, 32'({wb_aluout, wb_memdata}), 32'(0));
    chk({tag, "_wb_ctl"}, 32'({wb_waddr, wb_write_en, wb_mem_to_reg}), 32'(0));
    chk({tag, "_cnt"}, 32'(stall_cycles), 32'(0));
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    //      name        alu       rd2       wa  we mw mr m2r dly rdata
    issue("nop",       16'h1234, 16'h0000, 3, 1, 0, 0, 0, 0, 16'h0);
    issue("load",      16'h0042, 16'h0000, 5, 1, 0, 1, 1, 1, 16'hBEEF);
    issue("store",     16'h0010, 16'h5A5A, 0, 0, 1, 0, 0, 3, 16'h0);
    issue("rw_both",   16'h0077, 16'h1111, 6, 1, 1, 1, 1, 2, 16'h9999);
    issue("load_hi",   16'h1F80, 16'h0000, 7, 1, 0, 1, 1, 2, 16'h0F0F);
    spur = 1'b1;
    issue("nop_spur",  16'h00AA, 16'h0000, 2, 1, 0, 0, 0, 0, 16'h0);
    spur = 1'b0;
    issue("load_slow", 16'h0033, 16'h0000, 9, 1, 0, 1, 1, 4, 16'hC0DE);
    issue("nop2",      16'h4321, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0);

    // Load aborted by reset in the middle of ACCESS; no WB result expected.
    begin
      mem_t m;
      m.we = 1'b0; m.addr = 8'h50; m.wdata = 16'h0; m.dly = 50; m.rdata = 16'h0;
      exp_mem_q.push_back(m);
    end
    aluout_in = 16'h0050; rdata2_in = 16'h0; waddr_in = 4'd4; write_en_in = 1'b1;
    mem_write_in = 1'b0; mem_read_in = 1'b1; mem_to_reg_in = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_all_zero("midreset");
    $display("txn reset_abort: req=%0d stall=%0d stall_cycles=%0d", dmem_req, stall, stall_cycles);
    exp_total = 0;
    aluout_in = '0; waddr_in = '0; write_en_in = 1'b0;
    mem_read_in = 1'b0; mem_to_reg_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    issue("load_after", 16'h0021, 16'h0000, 8, 1, 0, 1, 1, 2, 16'hA5C3);
    issue("nop_end",    16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0);

    @(negedge clk);
    #1;
    chk("wb_queue_empty", 32'(exp_wb_q.size()), 32'(0));
    chk("mem_queue_empty", 32'(exp_mem_q.size()), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
